frame_sync_param: RTL and testbench
===================================

Name: frame_sync_param

Overview:
Parametrised frame synchroniser for the serial link receive path. Sits between the CDR bit output and the payload consumer. Hunts for a configurable sync word with a valid CRC-8, confirms alignment over several frames, then tracks frames at a fixed bit spacing with hysteresis on loss. Generalises the 56-bit fixed-format synchroniser to arbitrary data and counter widths, and adds lock/confirm states and richer error reporting.

Parameters:
DATA_W, 32, payload width in bits (8..64)
CNT_W, 8, frame-counter field width (1..16)
SYNC_W, 8, sync field width (4..16)
SYNC_PAT, 8'hAA, sync pattern (SYNC_W bits)
CRC_POLY, 8'h07, CRC-8 polynomial (x^8 implicit)
LOCK_CNT, 2, consecutive good frames to enter LOCKED (>=1, includes the HUNT frame)
LOSS_CNT, 8, consecutive bad frames in LOCKED to drop to HUNT (>=1)
Derived FRAME_W = SYNC_W+CNT_W+DATA_W+8. Frame on wire MSB first: {SYNC, CNT, DATA, CRC}.

Ports:
clk_sys  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
bit_in  in  1  recovered bit, sampled when bit_valid=1
bit_valid  in  1  bit strobe, any duty cycle, any gap length
data_out  out  DATA_W  payload of last good frame
cnt_out  out  CNT_W  counter field of last good frame
data_valid  out  1  1-cycle pulse, data_out/cnt_out updated
crc_error  out  1  1-cycle pulse, bad frame at expected boundary (CONFIRM/LOCKED)
cnt_error  out  1  1-cycle pulse, good frame with counter != expected
locked  out  1  level, high in LOCKED
sync_lost  out  1  1-cycle pulse on LOCKED->HUNT

Behaviour:
- Reset (async, rst_n=0): all outputs 0, window cleared to 0, state HUNT, bit position, good/bad counters and expected counter 0.
- Window: FRAME_W-bit shift register, shifts {win, bit_in} only on bit_valid. All evaluations use the post-shift window value and occur only on bit_valid cycles. Outputs are registered: pulses appear the cycle after the bit_valid that completed the frame. No evaluation when bit_valid=0.
- CRC: CRC-8 over SYNC..DATA (FRAME_W-8 bits), MSB first, init 0x00, no reflection, no xorout. Frame good = sync field==SYNC_PAT AND CRC matches.
- HUNT: evaluate every bit_valid. On a good frame: data_valid, latch data/cnt, expected = cnt+1 (mod 2^CNT_W), bit position reset, good_cnt=1. Go to LOCKED if LOCK_CNT==1, else CONFIRM. No crc_error pulses in HUNT.
- CONFIRM: evaluate only when exactly FRAME_W further bits have been shifted. Good frame with cnt==expected: data_valid, good_cnt++, go LOCKED when good_cnt reaches LOCK_CNT. Bad frame: crc_error, back to HUNT. Good frame with cnt mismatch: cnt_error, data_valid, stay in CONFIRM with good_cnt=1 and expected re-seeded.
- LOCKED: evaluate every FRAME_W bits. Good frame: data_valid, bad_cnt=0; on cnt mismatch also cnt_error and re-seed expected (stay locked). Bad frame: crc_error, bad_cnt++, expected++ (frame assumed lost); when bad_cnt reaches LOSS_CNT: sync_lost, locked=0, HUNT, bad_cnt=0. HUNT resumes searching from the next bit_valid.
- Counter wrap: expected after 2^CNT_W-1 is 0; not an error.
- data_out/cnt_out hold their value between data_valid pulses and are never updated by bad frames.
- locked asserts the cycle after the confirming frame's last bit and deasserts together with sync_lost.
- Reset mid-frame discards the partial frame. Bits arriving in the same cycle as reset release are ignored.

Optional Feature:
FRAME_SYNC_STATS_EN: when defined, adds outputs stat_good[15:0], stat_crc_err[15:0], stat_resync[7:0] and input stat_clr. These are saturating counters of data_valid, crc_error and sync_lost pulses. stat_clr=1 zeroes them, and clear takes priority over a same-cycle increment. They reset to 0. When the macro is undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then 4 back-to-back good frames (cnt 0x00..0x03, data 0xDEADBEEF+n, default params) preceded by 13 random bits -> data_valid after frames 1-4, locked=1 one cycle after frame 2, no error pulses.
- Locked stream, corrupt CRC of one frame -> crc_error single pulse, no data_valid for it, locked stays 1. Next good frame cnt==expected -> no cnt_error.
- Locked stream, 8 consecutive corrupted frames -> crc_error x8, sync_lost pulse and locked=0 after the 8th. A good frame inserted 3 bits later is found in HUNT (data_valid).
- Good frames with cnt 0xFE, 0xFF, 0x00 then skip to 0x05 -> no cnt_error at wrap, cnt_error on 0x05 with data_valid, locked remains 1.
- Random gaps of 0-5 idle cycles between bit_valid, DATA_W=16, CNT_W=4, LOCK_CNT=3 -> same outputs as gapless run, and locked after the 3rd frame.
- rst_n pulsed low mid-frame while locked -> all outputs 0 immediately (async), HUNT. The following good frame is reacquired with data_valid.

Source files
------------

// File: rtl/frame_sync_param.sv
// Purpose : serial-link frame synchroniser; hunts for {SYNC,CNT,DATA,CRC8} frames, confirms, then tracks at fixed spacing.
// Latency : all outputs registered; pulses appear one clk_sys after the bit_valid that completed the frame.
// Backpressure: none; bit_valid may have any duty cycle or gap, and nothing is evaluated on idle cycles.
//
// Ports: clk_sys/rst_n (async active-low); bit_in qualified by bit_valid;
//        data_out/cnt_out hold the last good frame; data_valid, crc_error, cnt_error and sync_lost are 1-cycle pulses;
//        locked is a level that is high while tracking.
// Optional: define FRAME_SYNC_STATS_EN to add the stat_clr input and the stat_good/stat_crc_err/stat_resync saturating counters.
module frame_sync_param #(
    parameter int              DATA_W   = 32,
    parameter int              CNT_W    = 8,
    parameter int              SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hAA,
    parameter logic [7:0]      CRC_POLY = 8'h07,
    parameter int              LOCK_CNT = 2,
    parameter int              LOSS_CNT = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              data_valid,
    output logic              crc_error,
    output logic              cnt_error,
    output logic              locked,
    output logic              sync_lost
`ifdef FRAME_SYNC_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_good,
    output logic [15:0]       stat_crc_err,
    output logic [7:0]        stat_resync
`endif
);

    localparam int FRAME_W = SYNC_W + CNT_W + DATA_W + 8;
    localparam int PAY_W   = FRAME_W - 8;
    localparam int POS_W   = $clog2(FRAME_W);
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(LOSS_CNT + 1);

    typedef struct packed {
        logic [SYNC_W-1:0] sync;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] data;
        logic [7:0]        crc;
    } frame_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    // CRC-8, MSB first, zero init, no reflection, no final xor.
    function automatic logic [7:0] crc8(input logic [PAY_W-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = PAY_W - 1; i >= 0; i--) begin
            if (c[7] ^ d[i]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t              state, state_nxt;
    // Only the newest FRAME_W-1 bits are stored; the incoming bit completes the
    // window, and the oldest bit would be shifted out unread anyway.
    logic [FRAME_W-2:0]  win_q;
    logic [POS_W-1:0]    bit_pos, bit_pos_nxt;
    logic [GOOD_W-1:0]   good_cnt, good_cnt_nxt, good_inc;
    logic [BAD_W-1:0]    bad_cnt, bad_cnt_nxt, bad_inc;
    logic [CNT_W-1:0]    exp_cnt, exp_cnt_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                data_valid_nxt, crc_error_nxt, cnt_error_nxt, sync_lost_nxt;
    logic                run_q;
    logic                shift;
    logic                at_boundary;
    logic                frame_good;
    frame_t              frame_nxt;

    // run_q stays low for the first edge after reset release so a bit arriving
    // in that cycle is dropped rather than racing the reset deassertion.
    assign shift       = bit_valid & run_q;
    assign frame_nxt   = {win_q, bit_in};
    assign frame_good  = (frame_nxt.sync == SYNC_PAT) &&
                         (crc8(frame_nxt[FRAME_W-1:8]) == frame_nxt.crc);
    // bit_pos counts bits since the last boundary; this bit is the FRAME_W-th.
    assign at_boundary = (bit_pos == POS_W'(FRAME_W - 1));
    assign good_inc    = good_cnt + 1'b1;
    assign bad_inc     = bad_cnt + 1'b1;
    assign locked      = (state == ST_LOCKED);

    always_comb begin
        state_nxt      = state;
        bit_pos_nxt    = bit_pos;
        good_cnt_nxt   = good_cnt;
        bad_cnt_nxt    = bad_cnt;
        exp_cnt_nxt    = exp_cnt;
        data_nxt       = data_out;
        cnt_nxt        = cnt_out;
        data_valid_nxt = 1'b0;
        crc_error_nxt  = 1'b0;
        cnt_error_nxt  = 1'b0;
        sync_lost_nxt  = 1'b0;

        if (shift) begin
            case (state)
                ST_HUNT: begin
                    if (frame_good) begin
                        data_valid_nxt = 1'b1;
                        data_nxt       = frame_nxt.data;
                        cnt_nxt        = frame_nxt.cnt;
                        exp_cnt_nxt    = frame_nxt.cnt + 1'b1;
                        bit_pos_nxt    = '0;
                        good_cnt_nxt   = GOOD_W'(1);
                        bad_cnt_nxt    = '0;
                        state_nxt      = (LOCK_CNT == 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM, ST_LOCKED: begin
                    if (!at_boundary) begin
                        bit_pos_nxt = bit_pos + 1'b1;
                    end else begin
                        bit_pos_nxt = '0;
                        if (frame_good) begin
                            data_valid_nxt = 1'b1;
                            data_nxt       = frame_nxt.data;
                            cnt_nxt        = frame_nxt.cnt;
                            // Expected counter is always re-seeded from the
                            // received one, so a skip is reported only once.
                            exp_cnt_nxt    = frame_nxt.cnt + 1'b1;
                            bad_cnt_nxt    = '0;
                            if (frame_nxt.cnt != exp_cnt) begin
                                cnt_error_nxt = 1'b1;
                                good_cnt_nxt  = GOOD_W'(1);
                            end else if (state == ST_CONFIRM) begin
                                good_cnt_nxt = good_inc;
                                if (good_inc >= GOOD_W'(LOCK_CNT)) begin
                                    state_nxt = ST_LOCKED;
                                end
                            end
                        end else begin
                            crc_error_nxt = 1'b1;
                            if (state == ST_CONFIRM) begin
                                state_nxt = ST_HUNT;
                            end else begin
                                // Treat the bad frame as lost so the next good
                                // frame's counter still lines up.
                                exp_cnt_nxt = exp_cnt + 1'b1;
                                if (bad_inc == BAD_W'(LOSS_CNT)) begin
                                    sync_lost_nxt = 1'b1;
                                    bad_cnt_nxt   = '0;
                                    state_nxt     = ST_HUNT;
                                end else begin
                                    bad_cnt_nxt = bad_inc;
                                end
                            end
                        end
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            win_q      <= '0;
            bit_pos    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            exp_cnt    <= '0;
            data_out   <= '0;
            cnt_out    <= '0;
            data_valid <= 1'b0;
            crc_error  <= 1'b0;
            cnt_error  <= 1'b0;
            sync_lost  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            if (shift) begin
                win_q <= frame_nxt[FRAME_W-2:0];
            end
            state      <= state_nxt;
            bit_pos    <= bit_pos_nxt;
            good_cnt   <= good_cnt_nxt;
            bad_cnt    <= bad_cnt_nxt;
            exp_cnt    <= exp_cnt_nxt;
            data_out   <= data_nxt;
            cnt_out    <= cnt_nxt;
            data_valid <= data_valid_nxt;
            crc_error  <= crc_error_nxt;
            cnt_error  <= cnt_error_nxt;
            sync_lost  <= sync_lost_nxt;
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stat_good    <= '0;
            stat_crc_err <= '0;
            stat_resync  <= '0;
        end else if (stat_clr) begin
            stat_good    <= '0;
            stat_crc_err <= '0;
            stat_resync  <= '0;
        end else begin
            if (data_valid_nxt && (stat_good != 16'hFFFF)) begin
                stat_good <= stat_good + 1'b1;
            end
            if (crc_error_nxt && (stat_crc_err != 16'hFFFF)) begin
                stat_crc_err <= stat_crc_err + 1'b1;
            end
            if (sync_lost_nxt && (stat_resync != 8'hFF)) begin
                stat_resync <= stat_resync + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_sync_param.sv
// Purpose : self-checking bench for frame_sync_param (default build and a narrow 16/4/LOCK3 build).
// Latency : checks each bit's outputs one clk_sys after the bit is presented, sampled on the falling edge.
// Backpressure: none; idle gaps between bits are randomised in one scenario.
`timescale 1ns/1ps
module tb_frame_sync_param;

    logic clk_sys;
    logic rst_n;
    logic bit_in;
    logic bit_valid;

    logic [31:0] data_a;
    logic [7:0]  cnt_a;
    logic        dv_a, crc_a, cnte_a, lk_a, lost_a;
    logic [15:0] data_b;
    logic [3:0]  cnt_b;
    logic        dv_b, crc_b, cnte_b, lk_b, lost_b;

`ifdef FRAME_SYNC_STATS_EN
    logic        stat_clr;
    logic [15:0] sg_a, sc_a, sg_b, sc_b;
    logic [7:0]  sr_a, sr_b;
    initial stat_clr = 1'b0;
`endif

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    frame_sync_param dut_a (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .data_out  (data_a),
        .cnt_out   (cnt_a),
        .data_valid(dv_a),
        .crc_error (crc_a),
        .cnt_error (cnte_a),
        .locked    (lk_a),
        .sync_lost (lost_a)
`ifdef FRAME_SYNC_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_good   (sg_a),
        .stat_crc_err(sc_a),
        .stat_resync (sr_a)
`endif
    );

    frame_sync_param #(.DATA_W(16), .CNT_W(4), .LOCK_CNT(3)) dut_b (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .data_out  (data_b),
        .cnt_out   (cnt_b),
        .data_valid(dv_b),
        .crc_error (crc_b),
        .cnt_error (cnte_b),
        .locked    (lk_b),
        .sync_lost (lost_b)
`ifdef FRAME_SYNC_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_good   (sg_b),
        .stat_crc_err(sc_b),
        .stat_resync (sr_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Active configuration (0 = default build, 1 = narrow build).
    int sel = 0;
    int c_sw, c_cw, c_dw, c_lock, c_loss, fw;

    bit q[$];
    localparam int MAXN = 4096;
    bit          x_dv[MAXN], x_crc[MAXN], x_cnte[MAXN], x_lost[MAXN], x_lk[MAXN];
    logic [63:0] x_data[MAXN];
    logic [15:0] x_cnt[MAXN];
    int o_dv, o_crc, o_cnte, o_lost, o_first_lock;

    // Observed flags: {data_valid, crc_error, cnt_error, sync_lost, locked}.
    logic [4:0]  obs_flags;
    logic [63:0] obs_data;
    logic [15:0] obs_cnt;
    always_comb begin
        if (sel == 1) begin
            obs_flags = {dv_b, crc_b, cnte_b, lost_b, lk_b};
            obs_data  = {48'd0, data_b};
            obs_cnt   = {12'd0, cnt_b};
        end else begin
            obs_flags = {dv_a, crc_a, cnte_a, lost_a, lk_a};
            obs_data  = {32'd0, data_a};
            obs_cnt   = {8'd0, cnt_a};
        end
    end

    task automatic set_cfg(input int s);
        sel    = s;
        c_sw   = 8;
        c_cw   = (s == 1) ? 4 : 8;
        c_dw   = (s == 1) ? 16 : 32;
        c_lock = (s == 1) ? 3 : 2;
        c_loss = 8;
        fw     = c_sw + c_cw + c_dw + 8;
    endtask

    function automatic logic [127:0] mask(input int n);
        logic [127:0] one;
        one = 128'd1;
        return (one << n) - one;
    endfunction

    // Textbook serial CRC-8 (poly 0x07), MSB of the nb-bit message first.
    function automatic logic [7:0] ref_crc(input logic [127:0] p, input int nb);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int j = nb - 1; j >= 0; j--) begin
            fb = c[7] ^ p[j];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic push_frame(input int cnt, input logic [63:0] data, input bit corrupt);
        logic [127:0] p;
        logic [7:0]   c;
        p = 128'h0AA;
        p = (p << c_cw) | (128'(cnt) & mask(c_cw));
        p = (p << c_dw) | (128'(data) & mask(c_dw));
        c = ref_crc(p, fw - 8);
        if (corrupt) c = c ^ 8'h01;
        for (int i = fw - 9; i >= 0; i--) q.push_back(p[i]);
        for (int i = 7; i >= 0; i--) q.push_back(c[i]);
    endtask

    function automatic bit bit_at(input int j);
        return (j < 0) ? 1'b0 : q[j];
    endfunction

    // Decode the FRAME_W bits ending at stream index e (zeros before the stream start).
    task automatic frame_at(input int e, output bit good, output logic [15:0] cnt, output logic [63:0] data);
        logic [127:0] w, pay, sy;
        w = '0;
        for (int i = 0; i < fw; i++) w = (w << 1) | 128'(bit_at(e - fw + 1 + i));
        pay  = w >> 8;
        data = 64'(pay & mask(c_dw));
        cnt  = 16'((pay >> c_dw) & mask(c_cw));
        sy   = (pay >> (c_dw + c_cw)) & mask(c_sw);
        good = (sy == 128'h0AA) && (ref_crc(pay, fw - 8) == w[7:0]);
    endtask

    // Reference: walk the stream frame by frame, jumping a whole frame once aligned
    // and a single bit while hunting; fill per-bit expectations over each span.
    task automatic run_model();
        int n, e, ph, run, bad, nxt, modc;
        logic [15:0] expc, cm, hc;
        logic [63:0] dm, hd;
        bit g;
        n = q.size();
        modc = 1 << c_cw;
        for (int k = 0; k < MAXN; k++) begin
            x_dv[k] = 0; x_crc[k] = 0; x_cnte[k] = 0; x_lost[k] = 0; x_lk[k] = 0;
            x_data[k] = '0; x_cnt[k] = '0;
        end
        e = 0; ph = 0; run = 0; bad = 0; expc = '0; hd = '0; hc = '0;
        while (e < n) begin
            frame_at(e, g, cm, dm);
            nxt = e + 1;
            if (ph == 0) begin
                if (g) begin
                    x_dv[e] = 1; hd = dm; hc = cm;
                    expc = 16'((int'(cm) + 1) % modc);
                    run = 1; bad = 0;
                    ph = (c_lock == 1) ? 2 : 1;
                    nxt = e + fw;
                end
            end else if (!g) begin
                x_crc[e] = 1;
                if (ph == 1) begin
                    ph = 0;
                end else begin
                    bad++;
                    expc = 16'((int'(expc) + 1) % modc);
                    if (bad == c_loss) begin
                        x_lost[e] = 1; ph = 0; bad = 0;
                    end else begin
                        nxt = e + fw;
                    end
                end
            end else begin
                x_dv[e] = 1; hd = dm; hc = cm;
                if (cm != expc) begin
                    x_cnte[e] = 1; run = 1;
                end else begin
                    run++;
                end
                if (ph == 1 && run >= c_lock) ph = 2;
                bad = 0;
                expc = 16'((int'(cm) + 1) % modc);
                nxt = e + fw;
            end
            for (int k = e; k < nxt && k < n; k++) begin
                x_lk[k] = (ph == 2); x_data[k] = hd; x_cnt[k] = hc;
            end
            e = nxt;
        end
    endtask

    // Must be entered just after a falling edge; returns just after one.
    task automatic drive_check(input string name, input int max_gap);
        int g;
        logic [4:0] want;
        run_model();
        o_dv = 0; o_crc = 0; o_cnte = 0; o_lost = 0; o_first_lock = -1;
        for (int k = 0; k < q.size(); k++) begin
            bit_in    = q[k];
            bit_valid = 1'b1;
            @(negedge clk_sys);
            bit_valid = 1'b0;
            want = {x_dv[k], x_crc[k], x_cnte[k], x_lost[k], x_lk[k]};
            checks++;
            if (obs_flags !== want) begin
                errors++;
                $display("FAIL %s flags bit %0d: got %b want %b", name, k, obs_flags, want);
            end
            checks++;
            if (obs_data !== x_data[k] || obs_cnt !== x_cnt[k]) begin
                errors++;
                $display("FAIL %s data bit %0d: got %h/%h want %h/%h", name, k, obs_data, obs_cnt, x_data[k], x_cnt[k]);
            end
            o_dv += int'(obs_flags[4]); o_crc += int'(obs_flags[3]);
            o_cnte += int'(obs_flags[2]); o_lost += int'(obs_flags[1]);
            if (o_first_lock < 0 && obs_flags[0]) o_first_lock = k;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                @(negedge clk_sys);
                checks++;
                if (obs_flags !== {4'b0000, x_lk[k]}) begin
                    errors++;
                    $display("FAIL %s idle after bit %0d: got %b want %b", name, k, obs_flags, {4'b0000, x_lk[k]});
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        bit_valid = 1'b0; bit_in = 1'b0; rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        set_cfg(0);
        #1 rst_n = 1'b0;
        #1;
        expect_int("reset_async_flags_a", int'(obs_flags), 0);
        repeat (2) @(negedge clk_sys);
        expect_int("reset_data_a", int'(obs_data[31:0] != 0) + int'(obs_cnt != 0), 0);
        set_cfg(1);
        #1;
        expect_int("reset_flags_b", int'(obs_flags), 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        expect_int("post_release_flags_b", int'(obs_flags), 0);
        set_cfg(0);
        #1;
        expect_int("post_release_flags_a", int'(obs_flags), 0);
    endtask

    task automatic test_acquire();
        set_cfg(0);
        apply_reset();
        push_rand(13);
        for (int n = 0; n < 4; n++) push_frame(n, 64'(32'hDEADBEEF + n), 1'b0);
        drive_check("acquire", 0);
        expect_int("acquire_dv_count", o_dv, 4);
        expect_int("acquire_err_count", o_crc + o_cnte + o_lost, 0);
        expect_int("acquire_lock_bit", o_first_lock, 13 + 2 * fw - 1);
    endtask

    task automatic test_crc_single();
        set_cfg(0);
        apply_reset();
        push_rand(13);
        for (int n = 0; n < 6; n++) push_frame(n, 64'($urandom), n == 3);
        drive_check("crc_single", 0);
        expect_int("crc_single_crc_count", o_crc, 1);
        expect_int("crc_single_dv_count", o_dv, 5);
        expect_int("crc_single_cnte_count", o_cnte, 0);
        expect_int("crc_single_locked", int'(obs_flags[0]), 1);
    endtask

    task automatic test_loss();
        set_cfg(0);
        apply_reset();
        push_rand(13);
        for (int n = 0; n < 11; n++) push_frame(n, 64'($urandom), n >= 3);
        push_rand(3);
        push_frame(32, 64'h0000_0000_1234_5678, 1'b0);
        drive_check("loss", 0);
        expect_int("loss_crc_count", o_crc, 8);
        expect_int("loss_lost_count", o_lost, 1);
        expect_int("loss_dv_count", o_dv, 4);
        expect_int("loss_locked_end", int'(obs_flags[0]), 0);
    endtask

    task automatic test_wrap();
        int seq[6] = '{'hFC, 'hFD, 'hFE, 'hFF, 'h00, 'h05};
        set_cfg(0);
        apply_reset();
        push_rand(5);
        for (int n = 0; n < 6; n++) push_frame(seq[n], 64'($urandom), 1'b0);
        drive_check("wrap", 0);
        expect_int("wrap_cnte_count", o_cnte, 1);
        expect_int("wrap_dv_count", o_dv, 6);
        expect_int("wrap_crc_count", o_crc, 0);
        expect_int("wrap_locked", int'(obs_flags[0]), 1);
    endtask

    task automatic test_gaps();
        bit saved[$];
        set_cfg(1);
        apply_reset();
        push_rand(13);
        for (int n = 0; n < 5; n++) push_frame(n, 64'($urandom), 1'b0);
        saved = q;
        drive_check("gapless_b", 0);
        expect_int("gapless_dv_count", o_dv, 5);
        expect_int("gapless_lock_bit", o_first_lock, 13 + 3 * fw - 1);
        apply_reset();
        q = saved;
        drive_check("gaps_b", 5);
        expect_int("gaps_dv_count", o_dv, 5);
        expect_int("gaps_lock_bit", o_first_lock, 13 + 3 * fw - 1);
        expect_int("gaps_locked_end", int'(obs_flags[0]), 1);
    endtask

    task automatic test_reset_mid();
        set_cfg(0);
        apply_reset();
        push_rand(13);
        for (int n = 0; n < 4; n++) push_frame(n, 64'($urandom), 1'b0);
        repeat (30) void'(q.pop_back());
        drive_check("pre_reset", 0);
        expect_int("pre_reset_locked", int'(obs_flags[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        expect_int("mid_reset_flags", int'(obs_flags), 0);
        expect_int("mid_reset_data", int'(obs_data != 0) + int'(obs_cnt != 0), 0);
        apply_reset();
        push_frame(64, 64'h0000_0000_CAFE_F00D, 1'b0);
        drive_check("reacquire", 0);
        expect_int("reacquire_dv_count", o_dv, 1);
        expect_int("reacquire_cnt", int'(obs_cnt), 64);
    endtask

    initial begin
        rst_n     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        test_reset();
        test_acquire();
        test_crc_single();
        test_loss();
        test_wrap();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
